// File: rtl/led_status_arbiter.sv
// led_status_arbiter
//    Owns the single front-panel status LED. Up to N_REQ requesters each ask for
//    a burst of flashes; bursts are granted round-robin, timed from tmb_clock0 in
//    units of TICK_DIV clocks, and the heartbeat waveform is shown while idle.
//
// Ports
//    tmb_clock0    in   1        clock, all logic on posedge
//    reset         in   1        synchronous, active-high
//    req           in   N_REQ    level request per requester
//    req_count     in   4*N_REQ  flash count per requester [4i+3:4i], 0 means 1
//    heartbeat_in  in   1        waveform shown on the LED while idle
//    grant         out  N_REQ    one-hot, high for the whole granted burst
//    done          out  N_REQ    one-cycle pulse to the granted requester at burst end
//    busy          out  1        high while a grant is active
//    led           out  1        registered LED drive
module led_status_arbiter #(
   parameter int N_REQ     = 4,
   parameter int TICK_DIV  = 400000,
   parameter int ON_TICKS  = 10,
   parameter int OFF_TICKS = 10,
   parameter int GAP_TICKS = 50
) (
   input  logic               tmb_clock0,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [4*N_REQ-1:0] req_count,
   input  logic               heartbeat_in,
   output logic [N_REQ-1:0]   grant,
   output logic [N_REQ-1:0]   done,
   output logic               busy,
   output logic               led
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLASH_ON  = 2'd1,
      FLASH_OFF = 2'd2,
      GAP       = 2'd3
   } state_t;

   state_t           state_r;
   logic [31:0]      tick_cnt_r;
   logic             tick_s;
   logic [7:0]       phase_r;
   logic [3:0]       flash_r;
   logic [IDX_W-1:0] rr_ptr_r;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_next_s;
   logic [IDX_W-1:0] cand_s;
   logic [IDX_W-1:0] pick_s;
   logic             pick_valid_s;
   logic [3:0]       pick_raw_s;
   logic [3:0]       pick_count_s;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign tick_s = (tick_cnt_r == 32'(TICK_DIV - 1));

   // Round-robin pick: scan offsets high to low so the nearest set bit at/after the pointer wins.
   always_comb begin
      pick_s       = '0;
      pick_valid_s = 1'b0;
      cand_s       = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand_s = IDX_W'((int'(rr_ptr_r) + i) % N_REQ);
         if (req[cand_s]) begin
            pick_s       = cand_s;
            pick_valid_s = 1'b1;
         end else begin
            pick_s       = pick_s;
            pick_valid_s = pick_valid_s;
         end
      end
   end

   // Flash count of the picked requester (0 is shown as a single flash) and next RR pointer.
   always_comb begin
      pick_raw_s = req_count[{pick_s, 2'b00} +: 4];
      if (pick_raw_s == 4'd0) begin
         pick_count_s = 4'd1;
      end else begin
         pick_count_s = pick_raw_s;
      end
      if (idx_r == IDX_W'(N_REQ - 1)) begin
         idx_next_s = '0;
      end else begin
         idx_next_s = idx_r + IDX_W'(1);
      end
   end

   // Tick prescaler: free-running, restarted on the grant edge so phases are exact multiples.
   always_ff @(posedge tmb_clock0) begin
      if (reset) begin
         tick_cnt_r <= 32'd0;
      end else if ((state_r == IDLE) && pick_valid_s) begin
         tick_cnt_r <= 32'd0;
      end else if (tick_s) begin
         tick_cnt_r <= 32'd0;
      end else begin
         tick_cnt_r <= tick_cnt_r + 32'd1;
      end
   end

   // Burst sequencer with registered grant/done/busy/led outputs.
   always_ff @(posedge tmb_clock0) begin
      if (reset) begin
         state_r  <= IDLE;
         grant    <= '0;
         done     <= '0;
         busy     <= 1'b0;
         led      <= 1'b0;
         rr_ptr_r <= '0;
         idx_r    <= '0;
         phase_r  <= 8'd0;
         flash_r  <= 4'd0;
      end else begin
         done <= '0;
         case (state_r)
            IDLE: begin
               if (pick_valid_s) begin
                  state_r <= FLASH_ON;
                  grant   <= onehot(pick_s);
                  busy    <= 1'b1;
                  led     <= 1'b1;
                  idx_r   <= pick_s;
                  flash_r <= pick_count_s;
                  phase_r <= 8'(ON_TICKS);
               end else begin
                  grant <= '0;
                  busy  <= 1'b0;
                  led   <= heartbeat_in;
               end
            end
            FLASH_ON: begin
               if (tick_s) begin
                  if (phase_r == 8'd1) begin
                     state_r <= FLASH_OFF;
                     led     <= 1'b0;
                     phase_r <= 8'(OFF_TICKS);
                  end else begin
                     phase_r <= phase_r - 8'd1;
                  end
               end
            end
            FLASH_OFF: begin
               if (tick_s) begin
                  if (phase_r == 8'd1) begin
                     // Last flash of the burst: go quiet for the gap instead of flashing again.
                     if (flash_r == 4'd1) begin
                        state_r <= GAP;
                        flash_r <= 4'd0;
                        phase_r <= 8'(GAP_TICKS);
                     end else begin
                        state_r <= FLASH_ON;
                        flash_r <= flash_r - 4'd1;
                        led     <= 1'b1;
                        phase_r <= 8'(ON_TICKS);
                     end
                  end else begin
                     phase_r <= phase_r - 8'd1;
                  end
               end
            end
            GAP: begin
               if (tick_s) begin
                  if (phase_r == 8'd1) begin
                     state_r  <= IDLE;
                     grant    <= '0;
                     busy     <= 1'b0;
                     led      <= 1'b0;
                     done     <= onehot(idx_r);
                     rr_ptr_r <= idx_next_s;
                     phase_r  <= 8'd0;
                  end else begin
                     phase_r <= phase_r - 8'd1;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               grant   <= '0;
               busy    <= 1'b0;
               led     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_status_arbiter.sv
module tb_led_status_arbiter;

   localparam int N_REQ     = 4;
   localparam int TICK_DIV  = 4;
   localparam int ON_TICKS  = 2;
   localparam int OFF_TICKS = 2;
   localparam int GAP_TICKS = 3;

   logic                 tmb_clock0 = 1'b0;
   logic                 reset;
   logic [N_REQ-1:0]     req;
   logic [4*N_REQ-1:0]   req_count;
   logic                 heartbeat_in;
   logic [N_REQ-1:0]     grant;
   logic [N_REQ-1:0]     done;
   logic                 busy;
   logic                 led;

   int checks   = 0;
   int failures = 0;

   always #5 tmb_clock0 = ~tmb_clock0;

   led_status_arbiter #(
      .N_REQ(N_REQ), .TICK_DIV(TICK_DIV), .ON_TICKS(ON_TICKS),
      .OFF_TICKS(OFF_TICKS), .GAP_TICKS(GAP_TICKS)
   ) dut (
      .tmb_clock0(tmb_clock0), .reset(reset), .req(req), .req_count(req_count),
      .heartbeat_in(heartbeat_in), .grant(grant), .done(done), .busy(busy), .led(led)
   );

   // Reference model: a burst is described by its start cycle, length and flash count;
   // LED level inside a burst follows from the offset with plain arithmetic.
   int cyc = 0;
   bit m_busy = 1'b0;
   int m_idx = 0, m_start = 0, m_len = 0, m_cnt = 0, m_rr = 0;
   logic [N_REQ-1:0] e_grant, e_done;
   logic e_busy, e_led;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic burst_led(input int off, input int cnt);
      int flash_cycles;
      flash_cycles = cnt * (ON_TICKS + OFF_TICKS) * TICK_DIV;
      if (off >= flash_cycles) return 1'b0;
      return ((off / TICK_DIV) % (ON_TICKS + OFF_TICKS)) < ON_TICKS;
   endfunction

   task automatic model_advance();
      int nxt;
      bit found;
      nxt = cyc + 1;
      e_grant = '0;
      e_done  = '0;
      e_busy  = 1'b0;
      e_led   = 1'b0;
      if (reset) begin
         m_busy = 1'b0;
         m_rr   = 0;
      end else if (m_busy) begin
         if (nxt == m_start + m_len) begin
            e_done[m_idx] = 1'b1;
            m_busy = 1'b0;
            m_rr   = (m_idx + 1) % N_REQ;
         end else begin
            e_grant[m_idx] = 1'b1;
            e_busy = 1'b1;
            e_led  = burst_led(nxt - m_start, m_cnt);
         end
      end else if (req != '0) begin
         found = 1'b0;
         for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(m_rr + k) % N_REQ]) begin
               m_idx = (m_rr + k) % N_REQ;
               found = 1'b1;
            end
         end
         m_cnt = int'(req_count[4*m_idx +: 4]);
         if (m_cnt == 0) m_cnt = 1;
         m_len   = (m_cnt * (ON_TICKS + OFF_TICKS) + GAP_TICKS) * TICK_DIV;
         m_start = nxt;
         m_busy  = 1'b1;
         e_grant[m_idx] = 1'b1;
         e_busy = 1'b1;
         e_led  = 1'b1;
      end else begin
         e_led = heartbeat_in;
      end
   endtask

   // One clock: predict from current inputs, clock, then compare against the model.
   task automatic step();
      model_advance();
      @(posedge tmb_clock0);
      #1;
      cyc++;
      check("model_grant", 32'(grant), 32'(e_grant));
      check("model_done",  32'(done),  32'(e_done));
      check("model_busy",  32'(busy),  32'(e_busy));
      check("model_led",   32'(led),   32'(e_led));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      step();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_led",   32'(led),   32'd0);
      reset = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [15:0] cnt;
      logic        hb;
      logic [3:0]  exp_grant;
      logic        exp_busy;
      logic        exp_led;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int led_on;
      int bad;
      logic exp_led_b;

      tbl[0] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[1] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0};
      tbl[2] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[3] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[4] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0};
      tbl[5] = '{4'b0100, 16'h0100, 1'b1, 4'b0100, 1'b1, 1'b1};
      tbl[6] = '{4'b0000, 16'h0000, 1'b0, 4'b0100, 1'b1, 1'b1};
      tbl[7] = '{4'b0000, 16'h0000, 1'b1, 4'b0100, 1'b1, 1'b1};

      reset = 1'b1; req = '0; req_count = '0; heartbeat_in = 1'b0;
      do_reset();

      // Idle heartbeat passthrough, then a grant from the idle state
      for (int i = 0; i < 8; i++) begin
         req = tbl[i].req; req_count = tbl[i].cnt; heartbeat_in = tbl[i].hb;
         step();
         check("tbl_grant", 32'(grant), 32'(tbl[i].exp_grant));
         check("tbl_busy",  32'(busy),  32'(tbl[i].exp_busy));
         check("tbl_led",   32'(led),   32'(tbl[i].exp_led));
      end
      heartbeat_in = 1'b0;
      do_reset();

      // Two-flash burst on requester 1
      req = 4'b0010; req_count = 16'h0020;
      for (int k = 1; k <= 46; k++) begin
         step();
         if (k == 1) req = '0;
         exp_led_b = (k <= 8) || (k >= 17 && k <= 24);
         if (k <= 44) begin
            check("t2_grant", 32'(grant), 32'h2);
            check("t2_led",   32'(led),   32'(exp_led_b));
            check("t2_done",  32'(done),  32'h0);
         end else if (k == 45) begin
            check("t2_done_pulse", 32'(done),  32'h2);
            check("t2_grant_fall", 32'(grant), 32'h0);
            check("t2_busy_fall",  32'(busy),  32'h0);
         end else begin
            check("t2_done_clear", 32'(done), 32'h0);
         end
      end
      do_reset();

      // All four requesting: RR order with one idle cycle between bursts
      req = 4'b1111; req_count = 16'h1111;
      for (int k = 1; k <= 145; k++) begin
         int b, o;
         logic [3:0] exp_g;
         step();
         b = (k - 1) / 29;
         o = (k - 1) % 29;
         exp_g = 4'b0001 << (b % 4);
         if (o == 0)  check("t3_grant_order", 32'(grant), 32'(exp_g));
         if (o == 27) check("t3_grant_hold",  32'(grant), 32'(exp_g));
         if (o == 28) begin
            check("t3_done",     32'(done),  32'(exp_g));
            check("t3_idle_gap", 32'(grant), 32'h0);
         end
      end
      req = '0;
      do_reset();

      // Count 0 is a single flash
      req = 4'b0100; req_count = 16'h0000;
      led_on = 0;
      for (int k = 1; k <= 29; k++) begin
         step();
         if (k == 1) req = '0;
         if (led) led_on++;
         if (k == 1)  check("t4_grant", 32'(grant), 32'h4);
         if (k == 28) check("t4_grant_hold", 32'(grant), 32'h4);
         if (k == 29) begin
            check("t4_done",       32'(done),  32'h4);
            check("t4_grant_fall", 32'(grant), 32'h0);
         end
      end
      check("t4_led_on_cycles", 32'(led_on), 32'd8);

      // Reset in the middle of FLASH_ON (pointer was 3 before the reset)
      req = 4'b1000; req_count = 16'h3000;
      step();
      req = '0;
      for (int k = 0; k < 3; k++) step();
      check("t5_pre_grant", 32'(grant), 32'h8);
      do_reset();
      req = 4'b1010; req_count = 16'h1111;
      step();
      req = '0;
      check("t5_rr_restart", 32'(grant), 32'h2);
      bad = 0;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (done[3]) bad++;
         if (k == 28) check("t5_done1", 32'(done), 32'h2);
      end
      check("t5_no_stale_done", 32'(bad), 32'd0);
      do_reset();

      // Request dropped mid-burst while another arrives
      req = 4'b0001; req_count = 16'h0001;
      for (int k = 1; k <= 31; k++) begin
         step();
         if (k == 10) req = 4'b1000;
         if (k == 29) check("t6_done0", 32'(done), 32'h1);
         if (k == 30) check("t6_grant3", 32'(grant), 32'h8);
      end
      do_reset();

      // Randomized traffic checked against the model every cycle
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (done[i]) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(15) == 0) begin
               req[i] = 1'b1;
               req_count[4*i +: 4] = 4'($urandom_range(5));
            end else if (req[i] && $urandom_range(63) == 0) begin
               req[i] = 1'b0;
            end
         end
         if ((n % 8) == 0) heartbeat_in = 1'($urandom_range(1));
         reset = ($urandom_range(999) == 0);
         step();
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
